// File: rtl/clef_sprite_renderer.sv
// clef_sprite_renderer
// Puts the treble clef on screen. It sits on both sides of the clef bitmap
// ROM. From the scan position it forms the ROM address. It then waits out the
// ROM's two-cycle read and carries the scan sideband alongside, so that it
// can composite the ROM bit over the background colour.
// The clef position is updated through a valid/ready handshake. A new
// position is held as pending and only becomes active at the next
// frame_start, so the clef never tears mid-frame.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   x, y, pix_valid       scan coordinate and active-video flag
//   frame_start           one-cycle pulse at the start of each frame
//   bg_rgb                background colour for the current x/y
//   pos_x_in, pos_y_in    requested clef top-left corner
//   pos_valid, pos_ready  handshake for the position request
//   rom_addr, rom_bit     clef ROM address out, ROM data back 2 cycles later
//   pix_valid_out         pix_valid delayed to the output
//   clef_on               output pixel is a set clef pixel
//   rgb_out               composited colour (4-cycle latency from x/y/bg_rgb)
module clef_sprite_renderer #(
  parameter int unsigned CLEF_W  = 32'd40,
  parameter int unsigned CLEF_H  = 32'd80,
  parameter int unsigned COORD_W = 32'd10,
  parameter int unsigned INIT_X  = 32'd20,
  parameter int unsigned INIT_Y  = 32'd100,
  parameter logic [11:0] FG_RGB  = 12'h000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic [11:0]        bg_rgb,
  input  logic [COORD_W-1:0] pos_x_in,
  input  logic [COORD_W-1:0] pos_y_in,
  input  logic               pos_valid,
  output logic               pos_ready,
  output logic [11:0]        rom_addr,
  input  logic               rom_bit,
  output logic               pix_valid_out,
  output logic               clef_on,
  output logic [11:0]        rgb_out
);

  localparam logic signed [COORD_W:0] CLEF_W_S = (COORD_W+1)'(CLEF_W);
  localparam logic signed [COORD_W:0] CLEF_H_S = (COORD_W+1)'(CLEF_H);
  localparam logic [COORD_W-1:0]      INIT_X_C = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0]      INIT_Y_C = COORD_W'(INIT_Y);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } pos_state_t;

  pos_state_t         state_r;
  logic [COORD_W-1:0] act_x_r;
  logic [COORD_W-1:0] act_y_r;
  logic [COORD_W-1:0] pend_x_r;
  logic [COORD_W-1:0] pend_y_r;

  logic signed [COORD_W:0] col_s;
  logic signed [COORD_W:0] row_s;
  logic [11:0]             col_u_s;
  logic [11:0]             row_u_s;
  logic [11:0]             addr_s;
  logic                    in_box_s;
  logic                    clef_on_next_s;

  // These delay stages line the sideband up with rom_bit.
  logic        pv_d1_r, pv_d2_r, pv_d3_r;
  logic        inbox_d1_r, inbox_d2_r, inbox_d3_r;
  logic [11:0] bg_d1_r, bg_d2_r, bg_d3_r;

  // The subtraction is one bit wider and signed. A scan position left of or
  // above the clef gives a negative offset, so the coordinates never wrap
  // into the box.
  assign col_s = $signed({1'b0, x}) - $signed({1'b0, act_x_r});
  assign row_s = $signed({1'b0, y}) - $signed({1'b0, act_y_r});

  assign in_box_s = pix_valid
                  && !col_s[COORD_W] && (col_s < CLEF_W_S)
                  && !row_s[COORD_W] && (row_s < CLEF_H_S);

  // row*40 is built from shifts. The product only matters inside the box,
  // where it stays below 3200.
  assign col_u_s = 12'(col_s);
  assign row_u_s = 12'(row_s);
  assign addr_s  = (row_u_s << 3'd5) + (row_u_s << 3'd3) + col_u_s;

  assign clef_on_next_s = pv_d3_r && inbox_d3_r && rom_bit;

  // Stage 1: ROM address plus the first sideband delay stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rom_addr   <= 12'd0;
      pv_d1_r    <= 1'b0;
      inbox_d1_r <= 1'b0;
      bg_d1_r    <= 12'd0;
    end else begin
      rom_addr   <= in_box_s ? addr_s : 12'd0;
      pv_d1_r    <= pix_valid;
      inbox_d1_r <= in_box_s;
      bg_d1_r    <= bg_rgb;
    end
  end

  // Stages 2 and 3: the sideband follows the address through the ROM read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pv_d2_r    <= 1'b0;
      pv_d3_r    <= 1'b0;
      inbox_d2_r <= 1'b0;
      inbox_d3_r <= 1'b0;
      bg_d2_r    <= 12'd0;
      bg_d3_r    <= 12'd0;
    end else begin
      pv_d2_r    <= pv_d1_r;
      pv_d3_r    <= pv_d2_r;
      inbox_d2_r <= inbox_d1_r;
      inbox_d3_r <= inbox_d2_r;
      bg_d2_r    <= bg_d1_r;
      bg_d3_r    <= bg_d2_r;
    end
  end

  // Output stage: composite the clef over the background.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pix_valid_out <= 1'b0;
      clef_on       <= 1'b0;
      rgb_out       <= 12'd0;
    end else begin
      pix_valid_out <= pv_d3_r;
      clef_on       <= clef_on_next_s;
      if (!pv_d3_r) begin
        rgb_out <= 12'd0;
      end else if (clef_on_next_s) begin
        rgb_out <= FG_RGB;
      end else begin
        rgb_out <= bg_d3_r;
      end
    end
  end

  // Position FSM: capture a request in IDLE and apply it at the next
  // frame_start. pos_ready is registered with the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      pos_ready <= 1'b1;
      act_x_r   <= INIT_X_C;
      act_y_r   <= INIT_Y_C;
      pend_x_r  <= '0;
      pend_y_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A frame_start in the capture cycle is ignored on purpose, so the
          // new position waits for the following frame.
          if (pos_valid && pos_ready) begin
            pend_x_r  <= pos_x_in;
            pend_y_r  <= pos_y_in;
            state_r   <= ST_PENDING;
            pos_ready <= 1'b0;
          end else begin
            pos_ready <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (frame_start) begin
            act_x_r   <= pend_x_r;
            act_y_r   <= pend_y_r;
            state_r   <= ST_IDLE;
            pos_ready <= 1'b1;
          end else begin
            pos_ready <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          pos_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clef_sprite_renderer.sv
module tb_clef_sprite_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  x, y, pos_x_in, pos_y_in;
  logic        pix_valid, frame_start, pos_valid, pos_ready;
  logic [11:0] bg_rgb, rom_addr, rgb_out;
  logic        rom_bit, pix_valid_out, clef_on;

  logic        rom_all_ones;
  logic        rom_q1;
  int          n_checks = 0;
  int          n_pass   = 0;

  localparam logic [11:0] BG = 12'hABC;

  clef_sprite_renderer dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .pix_valid(pix_valid),
    .frame_start(frame_start), .bg_rgb(bg_rgb), .pos_x_in(pos_x_in),
    .pos_y_in(pos_y_in), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .rom_addr(rom_addr), .rom_bit(rom_bit), .pix_valid_out(pix_valid_out),
    .clef_on(clef_on), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // ROM model with a 2-cycle read. The bitmap is either all ones or
  // addr[0]^addr[5].
  always @(posedge clk) begin
    rom_q1  <= rom_all_ones ? 1'b1 : (rom_addr[0] ^ rom_addr[5]);
    rom_bit <= rom_q1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated pixel: the address after 1 edge, nothing after 3 edges,
  // and the result after 4 edges.
  task automatic run_pix(input string tag, input int px, input int py, input logic pv,
                         input int exp_addr, input logic exp_on, input logic [11:0] exp_rgb);
    x = 10'(px); y = 10'(py); pix_valid = pv; bg_rgb = BG;
    step();
    chk({tag, ".addr"}, rom_addr, exp_addr);
    pix_valid = 1'b0; bg_rgb = 12'h0;
    step(); step();
    chk({tag, ".early"}, pix_valid_out, 0);
    step();
    chk({tag, ".pv"}, pix_valid_out, pv);
    chk({tag, ".on"}, clef_on, exp_on);
    chk({tag, ".rgb"}, rgb_out, exp_rgb);
  endtask

  // Raster-scan a window with an all-ones ROM. Counts the clef pixels and
  // the clef pixels that fall outside the 40x80 box at (bx,by).
  task automatic sweep(input string tag, input int x0, input int x1, input int y0,
                       input int y1, input int bx, input int by);
    int w, n, ones, outside;
    int hx[4], hy[4];
    logic hv[4];
    w = x1 - x0 + 1;
    n = w * (y1 - y0 + 1);
    ones = 0; outside = 0;
    for (int k = 0; k < 4; k++) begin hx[k] = 0; hy[k] = 0; hv[k] = 1'b0; end
    for (int i = 0; i < n + 3; i++) begin
      for (int k = 3; k > 0; k--) begin hx[k] = hx[k-1]; hy[k] = hy[k-1]; hv[k] = hv[k-1]; end
      if (i < n) begin
        hx[0] = x0 + (i % w); hy[0] = y0 + (i / w); hv[0] = 1'b1;
      end else begin
        hv[0] = 1'b0;
      end
      x = 10'(hx[0]); y = 10'(hy[0]); pix_valid = hv[0]; bg_rgb = BG;
      step();
      if (clef_on) begin
        ones++;
        if (!(hv[3] && hx[3] >= bx && hx[3] < bx + 40 && hy[3] >= by && hy[3] < by + 80))
          outside++;
      end
    end
    pix_valid = 1'b0;
    chk({tag, ".ones"}, ones, 3200);
    chk({tag, ".outside"}, outside, 0);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic request(input int px, input int py);
    pos_x_in = 10'(px); pos_y_in = 10'(py); pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; x = '0; y = '0; pix_valid = 1'b0; frame_start = 1'b0;
    bg_rgb = 12'h0; pos_x_in = '0; pos_y_in = '0; pos_valid = 1'b0;
    rom_all_ones = 1'b0;
    step(); step();
    chk("rst.ready", pos_ready, 1);
    chk("rst.addr", rom_addr, 0);
    chk("rst.pv", pix_valid_out, 0);
    chk("rst.on", clef_on, 0);
    chk("rst.rgb", rgb_out, 0);
    reset_n = 1'b1;
    step();

    // Patterned ROM at the default position (20,100).
    run_pix("p00",   20, 100, 1'b1, 0,    1'b0, BG);
    run_pix("p01",   21, 100, 1'b1, 1,    1'b1, 12'h000);
    run_pix("p42",   22, 101, 1'b1, 42,   1'b1, 12'h000);
    run_pix("pmax",  59, 179, 1'b1, 3199, 1'b0, BG);
    // All-ones ROM: the in-box gating alone decides the result.
    rom_all_ones = 1'b1;
    run_pix("omax",  59, 179, 1'b1, 3199, 1'b1, 12'h000);
    run_pix("right", 60, 179, 1'b1, 0,    1'b0, BG);
    run_pix("left",  19, 100, 1'b1, 0,    1'b0, BG);
    run_pix("above", 20, 99,  1'b1, 0,    1'b0, BG);
    run_pix("below", 20, 180, 1'b1, 0,    1'b0, BG);
    run_pix("nopv",  30, 120, 1'b0, 0,    1'b0, 12'h000);

    sweep("sw0", 0, 99, 90, 189, 20, 100);

    // Mid-frame request. The position is held until frame_start, and
    // pos_valid is ignored while PENDING.
    request(300, 50);
    chk("req.ready_drop", pos_ready, 0);
    run_pix("req.old", 20, 100, 1'b1, 0, 1'b1, 12'h000);
    request(5, 5);
    chk("req.still_pend", pos_ready, 0);
    pulse_frame();
    chk("req.ready_back", pos_ready, 1);
    sweep("sw1", 280, 359, 40, 139, 300, 50);
    run_pix("req.gone", 20, 100, 1'b1, 0, 1'b0, BG);

    // A request and frame_start in the same IDLE cycle: the new position
    // applies only at the second frame_start.
    pos_x_in = 10'd200; pos_y_in = 10'd300; pos_valid = 1'b1; frame_start = 1'b1;
    step();
    pos_valid = 1'b0; frame_start = 1'b0;
    chk("same.ready", pos_ready, 0);
    run_pix("same.keep", 300, 50, 1'b1, 0, 1'b1, 12'h000);
    pulse_frame();
    chk("same.ready_back", pos_ready, 1);
    run_pix("same.new", 200, 300, 1'b1, 0, 1'b0 | 1'b1, 12'h000);
    run_pix("same.oldoff", 300, 50, 1'b1, 0, 1'b0, BG);

    // Reset while PENDING, with a pixel in flight.
    request(400, 400);
    chk("rp.pending", pos_ready, 0);
    x = 10'd200; y = 10'd300; pix_valid = 1'b1; bg_rgb = BG;
    step();
    reset_n = 1'b0;
    step();
    chk("rp.ready", pos_ready, 1);
    chk("rp.pv", pix_valid_out, 0);
    chk("rp.rgb", rgb_out, 0);
    reset_n = 1'b1; pix_valid = 1'b0;
    step(); step(); step();
    chk("rp.flushed", pix_valid_out, 0);
    pulse_frame();
    run_pix("rp.default", 20, 100, 1'b1, 0, 1'b1, 12'h000);
    run_pix("rp.dropped", 400, 400, 1'b1, 0, 1'b0, BG);

    // Clef past the right edge: it clips, and low x never wraps into the box.
    request(1000, 100);
    pulse_frame();
    run_pix("clip.in", 1023, 100, 1'b1, 23, 1'b1, 12'h000);
    run_pix("clip.wrap", 5, 100, 1'b1, 0, 1'b0, BG);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
